// File: rtl/loader_pkg.sv
// Shared types for the SAP program loader: FSM state encoding and the SAP opcode set
// used to build program images.
package loader_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StCheck,
    StHold,
    StRun
  } loader_state_e;

  localparam logic [3:0] OpNop = 4'h0;
  localparam logic [3:0] OpLda = 4'h1;
  localparam logic [3:0] OpAdd = 4'h2;
  localparam logic [3:0] OpSub = 4'h3;
  localparam logic [3:0] OpSta = 4'h4;
  localparam logic [3:0] OpLdi = 4'h5;
  localparam logic [3:0] OpJmp = 4'h6;
  localparam logic [3:0] OpJc  = 4'h7;
  localparam logic [3:0] OpJz  = 4'h8;
  localparam logic [3:0] OpOut = 4'hE;
  localparam logic [3:0] OpHlt = 4'hF;

  function automatic logic [7:0] mk_instr(input logic [3:0] op, input logic [3:0] arg);
    return {op, arg};
  endfunction

endpackage

// File: rtl/prog_loader_if.sv
// Byte-stream input handshake plus RAM write port of the program loader.
interface prog_loader_if #(
  parameter int unsigned ADDR_W = 4
);
  logic [7:0]        in_data;
  logic              in_valid;
  logic              in_ready;
  logic [ADDR_W-1:0] ram_addr;
  logic [7:0]        ram_data;
  logic              ram_we;

  modport master (
    output in_data, in_valid,
    input  in_ready, ram_addr, ram_data, ram_we
  );

  modport slave (
    input  in_data, in_valid,
    output in_ready, ram_addr, ram_data, ram_we
  );
endinterface

// File: rtl/loader_hold_ctr.sv
// Loadable down-counter that times the CPU clear-hold window; zero flags expiry.
module loader_hold_ctr #(
  parameter int unsigned W = 3
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         load,
  input  logic         dec,
  input  logic [W-1:0] val,
  output logic         zero
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_q <= cnt_q - W'(1);
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/prog_loader.sv
// Streams a program image into the SAP board RAM while holding the CPU in clear.
// Optional trailing checksum byte is enabled by defining LOADER_CHECKSUM_EN.
module prog_loader
  import loader_pkg::*;
#(
  parameter int unsigned NWORDS   = 16,
  parameter int unsigned ADDR_W   = 4,
  parameter int unsigned CLR_HOLD = 4
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             load_start,
  prog_loader_if.slave     bus,
  output logic             cpu_clr,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int unsigned CW = ADDR_W + 1;
  localparam int unsigned HW = $clog2(CLR_HOLD + 2);
  localparam logic [CW-1:0] LastIdx = CW'(NWORDS - 1);
  // One extra count covers the cycle in which the last registered ram_we is still high.
  localparam logic [HW-1:0] HoldLoad = HW'(CLR_HOLD + 1);

  loader_state_e     state_q, state_d;
  logic [CW-1:0]     cnt_q;
  logic [ADDR_W-1:0] addr_q;
  logic [7:0]        data_q;
  logic              we_q;
  logic              accept, start, last;
  logic              hold_load, hold_zero;

  assign accept = bus.in_valid && bus.in_ready;
  assign start  = load_start && ((state_q == StIdle) || (state_q == StRun));
  assign last   = (cnt_q == LastIdx);

`ifdef LOADER_CHECKSUM_EN
  logic [7:0] sum_q, sum_nx;
  logic       err_q, sum_ok;
  assign sum_nx = sum_q + bus.in_data;
  assign sum_ok = (sum_nx == 8'h00);
  assign err    = err_q;
`else
  assign err = 1'b0;
`endif

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle, StRun: if (load_start) state_d = StLoad;
      StLoad: begin
        if (accept && last) begin
`ifdef LOADER_CHECKSUM_EN
          state_d = StCheck;
`else
          state_d = StHold;
`endif
        end
      end
      StCheck: begin
`ifdef LOADER_CHECKSUM_EN
        if (accept) state_d = sum_ok ? StHold : StIdle;
`else
        state_d = StIdle;
`endif
      end
      StHold: if (hold_zero) state_d = StRun;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    bus.in_ready = 1'b0;
    cpu_clr      = 1'b1;
    busy         = 1'b0;
    done         = 1'b0;
    unique case (state_q)
      StLoad, StCheck: begin
        bus.in_ready = 1'b1;
        busy         = 1'b1;
      end
      StHold: busy = 1'b1;
      StRun: begin
        cpu_clr = 1'b0;
        done    = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      cnt_q  <= '0;
      addr_q <= '0;
      data_q <= '0;
      we_q   <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      sum_q  <= '0;
      err_q  <= 1'b0;
`endif
    end else begin
      we_q <= 1'b0;
      if (start) begin
        cnt_q <= '0;
`ifdef LOADER_CHECKSUM_EN
        sum_q <= '0;
        err_q <= 1'b0;
`endif
      end else if ((state_q == StLoad) && accept) begin
        we_q   <= 1'b1;
        addr_q <= cnt_q[ADDR_W-1:0];
        data_q <= bus.in_data;
        cnt_q  <= cnt_q + CW'(1);
`ifdef LOADER_CHECKSUM_EN
        sum_q  <= sum_nx;
      end else if ((state_q == StCheck) && accept && !sum_ok) begin
        err_q  <= 1'b1;
`endif
      end
    end
  end

  assign bus.ram_we   = we_q;
  assign bus.ram_addr = addr_q;
  assign bus.ram_data = data_q;

  assign hold_load = (state_q != StHold) && (state_d == StHold);

  loader_hold_ctr #(
    .W (HW)
  ) u_hold_ctr (
    .clk  (clk),
    .clr  (clr),
    .load (hold_load),
    .dec  (state_q == StHold),
    .val  (HoldLoad),
    .zero (hold_zero)
  );

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: loads the SAP add program and runs it on a small
// instruction-level CPU model built from the captured RAM writes.
module tb_prog_loader;
  import loader_pkg::*;

  logic clk = 1'b0;
  logic clr = 1'b1;
  logic load_start = 1'b0;
  logic cpu_clr, busy, done, err;

  prog_loader_if #(.ADDR_W(4)) bus ();

  prog_loader #(
    .NWORDS   (16),
    .ADDR_W   (4),
    .CLR_HOLD (4)
  ) dut (
    .clk        (clk),
    .clr        (clr),
    .load_start (load_start),
    .bus        (bus),
    .cpu_clr    (cpu_clr),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int we_cnt = 0;
  int addr_bad = 0;
  int data_bad = 0;
  int last_we_cyc = 0;
  int fall_cyc = 0;
  int we0, ab0, db0;
  logic [3:0] exp_addr = 4'h0;
  logic prev_clr = 1'b1;
  logic prev_busy = 1'b0;
  logic [7:0] img [16];
  logic [7:0] ram [16];

  always @(posedge clk) cyc <= cyc + 1;

  // RAM capture: a new load (busy rising) must restart the address sequence at 0.
  always @(negedge clk) begin
    if (busy && !prev_busy) exp_addr = 4'h0;
    if (bus.ram_we) begin
      if (bus.ram_addr != exp_addr) addr_bad++;
      if (bus.ram_data != img[bus.ram_addr]) data_bad++;
      ram[bus.ram_addr] = bus.ram_data;
      exp_addr++;
      we_cnt++;
      last_we_cyc = cyc;
    end
    if (prev_clr && !cpu_clr) fall_cyc = cyc;
    prev_clr = cpu_clr;
    prev_busy = busy;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] run_cpu();
    logic [7:0] m [16];
    logic [7:0] a, o, ir;
    logic [8:0] s;
    logic [3:0] pc;
    logic c, z;
    for (int i = 0; i < 16; i++) m[i] = ram[i];
    a = 8'h00; o = 8'h00; pc = 4'h0; c = 1'b0; z = 1'b0;
    for (int st = 0; st < 64; st++) begin
      ir = m[pc];
      pc = pc + 4'h1;
      if (ir[7:4] == OpHlt) break;
      case (ir[7:4])
        OpLda: a = m[ir[3:0]];
        OpAdd: begin s = {1'b0, a} + {1'b0, m[ir[3:0]]}; a = s[7:0]; c = s[8]; z = (a == 0); end
        OpSub: begin s = {1'b0, a} - {1'b0, m[ir[3:0]]}; a = s[7:0]; c = s[8]; z = (a == 0); end
        OpSta: m[ir[3:0]] = a;
        OpLdi: a = {4'h0, ir[3:0]};
        OpJmp: pc = ir[3:0];
        OpJc:  if (c) pc = ir[3:0];
        OpJz:  if (z) pc = ir[3:0];
        OpOut: o = a;
        default: ;
      endcase
    end
    return o;
  endfunction

  task automatic start_load();
    @(negedge clk);
    load_start = 1'b1;
    @(negedge clk);
    load_start = 1'b0;
    check("ready after start", bus.in_ready, 1);
  endtask

  task automatic send(input logic [7:0] b);
    int n = 0;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    while (!bus.in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("ready wait", n < 20, 1);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
  endtask

  task automatic load_image(input int stall);
    we0 = we_cnt; ab0 = addr_bad; db0 = data_bad;
    start_load();
    for (int i = 0; i < 16; i++) begin
      send(img[i]);
      repeat (stall) @(posedge clk);
    end
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("done wait", n < 100, 1);
    @(negedge clk);
  endtask

  task automatic after_load(input string tag);
    wait_done();
    check({tag, " done"}, done, 1);
    check({tag, " cpu_clr"}, cpu_clr, 0);
    check({tag, " busy"}, busy, 0);
    check({tag, " err"}, err, 0);
    check({tag, " writes"}, we_cnt - we0, 16);
    check({tag, " addr order"}, addr_bad - ab0, 0);
    check({tag, " data"}, data_bad - db0, 0);
`ifndef LOADER_CHECKSUM_EN
    // Tags are taken mid-pulse: pulse end is one cycle later, then CLR_HOLD+1 = 5 more.
    check({tag, " clr release"}, fall_cyc - last_we_cyc, 6);
`endif
    check({tag, " cpu out"}, run_cpu(), 8'h5B);
  endtask

  task automatic check_reset(input string tag);
    check({tag, " cpu_clr"}, cpu_clr, 1);
    check({tag, " in_ready"}, bus.in_ready, 0);
    check({tag, " ram_we"}, bus.ram_we, 0);
    check({tag, " ram_addr"}, bus.ram_addr, 0);
    check({tag, " ram_data"}, bus.ram_data, 0);
    check({tag, " busy"}, busy, 0);
    check({tag, " done"}, done, 0);
    check({tag, " err"}, err, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int w1;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    for (int i = 0; i < 16; i++) begin
      img[i] = 8'h00;
      ram[i] = 8'hFF;
    end
    img[0]  = mk_instr(OpLda, 4'hE);
    img[1]  = mk_instr(OpAdd, 4'hF);
    img[2]  = mk_instr(OpOut, 4'h0);
    img[3]  = mk_instr(OpHlt, 4'h0);
    img[14] = 8'h38;
    img[15] = 8'h23;

    repeat (3) @(negedge clk);
    check_reset("por");
    clr = 1'b0;

    // Back-to-back add program.
    load_image(0);
`ifdef LOADER_CHECKSUM_EN
    send(8'h88);
`endif
    after_load("add");

    // Three idle cycles between bytes; RAM image must be identical.
    for (int i = 0; i < 16; i++) ram[i] = 8'hFF;
    load_image(3);
`ifdef LOADER_CHECKSUM_EN
    send(8'h88);
`endif
    after_load("stall");

    // load_start mid-LOAD must not restart; in_valid in RUN must not write.
    we0 = we_cnt; ab0 = addr_bad; db0 = data_bad;
    start_load();
    for (int i = 0; i < 16; i++) begin
      send(img[i]);
      if (i == 5) begin
        @(negedge clk);
        load_start = 1'b1;
        @(negedge clk);
        load_start = 1'b0;
      end
    end
`ifdef LOADER_CHECKSUM_EN
    send(8'h88);
`endif
    after_load("ignore");
    w1 = we_cnt;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'hAA;
    repeat (5) @(negedge clk);
    check("run in_ready", bus.in_ready, 0);
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("run no write", we_cnt - w1, 0);
    check("run done held", done, 1);

    // Asynchronous reset right after byte 7, while its write pulse is high.
    start_load();
    for (int i = 0; i < 8; i++) send(img[i]);
    #2 clr = 1'b1;
    #1 check_reset("midload");
    @(negedge clk);
    clr = 1'b0;
    for (int i = 0; i < 16; i++) ram[i] = 8'hFF;
    load_image(0);
`ifdef LOADER_CHECKSUM_EN
    send(8'h88);
`endif
    after_load("reload");

`ifdef LOADER_CHECKSUM_EN
    // Image sums to 0x78, so 0x89 is a wrong checksum.
    begin
      int n = 0;
      load_image(0);
      send(8'h89);
      while (busy && n < 50) begin
        @(negedge clk);
        n++;
      end
      check("ck bad idle wait", n < 50, 1);
      check("ck bad err", err, 1);
      check("ck bad cpu_clr", cpu_clr, 1);
      check("ck bad done", done, 0);
      check("ck bad writes", we_cnt - we0, 16);
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
